data_mem_responder: RTL and testbench

Data-memory responder on the CPU load/store path: accepts one load or store request per valid/ready handshake and performs the RISC-V byte, halfword or word access against an internal word array after a fixed number of wait states. It returns a valid/ready response whose `memData` drives the memory-data input of the writeback select. Misaligned, out-of-range and illegal-width accesses are flagged and have no side effects.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the CPU datapath and the
// data-memory responder.
interface data_mem_responder_if #(
  parameter int ADDR_SIZE = 32
);

  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [2:0]           reqFunct3;
  logic [ADDR_SIZE-1:0] reqAddr;
  logic [31:0]          reqWData;
  logic                 respValid;
  logic                 respReady;
  logic [31:0]          memData;
  logic                 respFault;

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqWData, respReady,
    input  reqReady, respValid, memData, respFault
  );

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqWData, respReady,
    output reqReady, respValid, memData, respFault
  );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one RISC-V byte/halfword/word load or store per
// handshake, performed against an internal word array after WAIT_CYCLES.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_SIZE   = 32
) (
  input logic                clk,
  input logic                rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t               state;
  logic [3:0]           count;
  logic                 cap_write;
  logic [2:0]           cap_funct3;
  logic [ADDR_SIZE-1:0] cap_addr;
  logic [31:0]          cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic                 in_idle;
  logic                 accept;
  logic                 do_access;
  logic                 sel_write;
  logic [2:0]           sel_funct3;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [31:0]          sel_wdata;
  logic [1:0]           lane;
  logic [ADDR_SIZE-3:0] word_idx;
  logic [AW-1:0]        mem_idx;
  logic                 bad_width;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 fault;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [31:0]          load_data;
  logic [31:0]          wr_word;
  logic [31:0]          resp_data;
  logic                 mem_we;

  // With zero wait states the access happens on the accept edge itself, so
  // the request fields come straight off the bus instead of the capture regs.
  always_comb begin
    in_idle    = (state == ST_IDLE);
    accept     = in_idle && bus.reqValid && bus.reqReady;
    sel_write  = in_idle ? bus.reqWrite  : cap_write;
    sel_funct3 = in_idle ? bus.reqFunct3 : cap_funct3;
    sel_addr   = in_idle ? bus.reqAddr   : cap_addr;
    sel_wdata  = in_idle ? bus.reqWData  : cap_wdata;
    lane       = sel_addr[1:0];
    word_idx   = sel_addr[ADDR_SIZE-1:2];
    mem_idx    = sel_addr[AW+1:2];
    do_access  = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                          (state == ST_WAIT && count == 4'd0));
  end

  always_comb begin
    bad_width    = sel_write ? (sel_funct3 > 3'd2)
                             : (sel_funct3 == 3'b011 || sel_funct3[2:1] == 2'b11);
    misaligned   = (sel_funct3[1:0] == 2'b01 && lane[0]) ||
                   (sel_funct3[1:0] == 2'b10 && lane != 2'b00);
    out_of_range = {1'b0, word_idx} >= (ADDR_SIZE-1)'(DEPTH_WORDS);
    fault        = bad_width || misaligned || out_of_range;
  end

  always_comb begin
    rd_word = mem[mem_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (sel_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
    resp_data = (fault || sel_write) ? 32'd0 : load_data;
  end

  // Stores merge the new bytes into the existing word so untouched lanes survive.
  always_comb begin
    wr_word = rd_word;
    unique case (sel_funct3[1:0])
      2'b00:   wr_word[{lane, 3'b000} +: 8]      = sel_wdata[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = sel_wdata[15:0];
      2'b10:   wr_word                           = sel_wdata;
      default: wr_word                           = rd_word;
    endcase
    mem_we = do_access && sel_write && !fault;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= 4'd0;
      cap_write     <= 1'b0;
      cap_funct3    <= 3'd0;
      cap_addr      <= '0;
      cap_wdata     <= 32'd0;
      bus.reqReady  <= 1'b0;
      bus.respValid <= 1'b0;
      bus.memData   <= 32'd0;
      bus.respFault <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_write    <= bus.reqWrite;
            cap_funct3   <= bus.reqFunct3;
            cap_addr     <= bus.reqAddr;
            cap_wdata    <= bus.reqWData;
            bus.reqReady <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state         <= ST_RESP;
              bus.respValid <= 1'b1;
              bus.memData   <= resp_data;
              bus.respFault <= fault;
            end else begin
              state <= ST_WAIT;
              count <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            bus.reqReady <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (count == 4'd0) begin
            state         <= ST_RESP;
            bus.respValid <= 1'b1;
            bus.memData   <= resp_data;
            bus.respFault <= fault;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.respReady) begin
            state         <= ST_IDLE;
            bus.respValid <= 1'b0;
            bus.reqReady  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed reference
// memory; a second instance covers the zero-wait-state configuration.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  resp_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [0:4*DEPTH-1];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_SIZE(32)) bus_a ();
  data_mem_responder_if #(.ADDR_SIZE(32)) bus_b ();

  assign bus_a.reqValid  = req_valid[0];
  assign bus_a.respReady = resp_ready[0];
  assign bus_a.reqWrite  = req_write;
  assign bus_a.reqFunct3 = req_funct3;
  assign bus_a.reqAddr   = req_addr;
  assign bus_a.reqWData  = req_wdata;
  assign bus_b.reqValid  = req_valid[1];
  assign bus_b.respReady = resp_ready[1];
  assign bus_b.reqWrite  = req_write;
  assign bus_b.reqFunct3 = req_funct3;
  assign bus_b.reqAddr   = req_addr;
  assign bus_b.reqWData  = req_wdata;

  wire        obs_req_ready  = sel ? bus_b.reqReady  : bus_a.reqReady;
  wire        obs_resp_valid = sel ? bus_b.respValid : bus_a.respValid;
  wire [31:0] obs_mem_data   = sel ? bus_b.memData   : bus_a.memData;
  wire        obs_resp_fault = sel ? bus_b.respFault : bus_a.respFault;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_SIZE(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_SIZE(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: the array is a flat byte memory; accesses are size/sign rules only.
  function automatic void model_access(input bit wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output bit flt, output logic [31:0] data);
    int size = 1;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    logic [63:0] v;
    if (wr) begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0:    begin size = 1; sgn = 1'b1; end
        3'd4:    size = 1;
        3'd1:    begin size = 2; sgn = 1'b1; end
        3'd5:    size = 2;
        3'd2:    size = 4;
        default: legal = 1'b0;
      endcase
    end
    flt  = !legal || (addr % size != 0) || (addr / 4 >= DEPTH);
    data = 32'd0;
    if (!flt) begin
      if (wr) begin
        for (int i = 0; i < size; i++) model_mem[addr + i] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < size; i++) v = v | (64'(model_mem[addr + i]) << (8*i));
        if (sgn && v[8*size-1]) v = v | (~64'd0 << (8*size));
        data = v[31:0];
      end
    end
  endfunction

  task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int hold,
                               output logic [31:0] data, output bit flt, output int lat);
    int guard;
    @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid[sel] = 1'b1;
    guard = 0;
    while (!obs_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_ready_before_accept", 32'(obs_req_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid[sel] = 1'b0;
      lat++;
    end while (!obs_resp_valid && lat < 50);
    data = obs_mem_data;
    flt  = obs_resp_fault;
    repeat (hold) @(negedge clk);
    checkOutput("held_mem_data", obs_mem_data, data);
    resp_ready[sel] = 1'b1;
    @(negedge clk);
    resp_ready[sel] = 1'b0;
    checkOutput("idle_after_resp", {30'd0, obs_resp_valid, obs_req_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] data, output bit flt);
    bit          exp_flt;
    logic [31:0] exp_data;
    int          lat;
    model_access(wr, f3, addr, wd, exp_flt, exp_data);
    applyStimulus(wr, f3, addr, wd, hold, data, flt, lat);
    checkOutput({tag, "_data"}, data, exp_data);
    checkOutput({tag, "_fault"}, 32'(flt), 32'(exp_flt));
    checkOutput({tag, "_latency"}, lat, 32'd3);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    bit          f;
    int          lat;
    int          guard;
    logic [31:0] held;

    sel        = 1'b0;
    resp_ready = 2'b00;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_wdata  = 32'h0BADF00D;
    req_valid  = 2'b11;
    rst        = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus_a.reqReady), 32'd0);
    checkOutput("reset_resp_valid", 32'(bus_a.respValid), 32'd0);
    checkOutput("reset_mem_data", bus_a.memData, 32'd0);
    checkOutput("reset_resp_fault", 32'(bus_a.respFault), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_req_ready_a", 32'(bus_a.reqReady), 32'd1);
    checkOutput("release_req_ready_b", 32'(bus_b.reqReady), 32'd1);
    checkOutput("release_no_accept", 32'(bus_a.respValid), 32'd0);
    req_valid = 2'b00;

    for (int w = 0; w < 32; w++) runOp("preload", 1'b1, 3'd2, 32'(w * 4), $urandom, 0, d, f);

    runOp("sw_0x10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, d, f);
    checkOutput("sw_0x10_zero_data", d, 32'd0);
    runOp("lw_0x10", 1'b0, 3'd2, 32'h10, 32'd0, 0, d, f);
    checkOutput("lw_0x10_const", d, 32'hDEADBEEF);

    runOp("sb_0x13", 1'b1, 3'd0, 32'h13, 32'h80, 0, d, f);
    runOp("lb_0x13", 1'b0, 3'd0, 32'h13, 32'd0, 0, d, f);
    checkOutput("lb_0x13_const", d, 32'hFFFFFF80);
    runOp("lbu_0x13", 1'b0, 3'd4, 32'h13, 32'd0, 0, d, f);
    checkOutput("lbu_0x13_const", d, 32'h00000080);
    runOp("lh_0x12", 1'b0, 3'd1, 32'h12, 32'd0, 0, d, f);
    checkOutput("lh_0x12_const", d, 32'hFFFF80AD);
    runOp("lhu_0x12", 1'b0, 3'd5, 32'h12, 32'd0, 0, d, f);
    checkOutput("lhu_0x12_const", d, 32'h000080AD);
    runOp("lw_merged", 1'b0, 3'd2, 32'h10, 32'd0, 0, d, f);
    checkOutput("lw_merged_const", d, 32'h80ADBEEF);

    runOp("lw_misaligned", 1'b0, 3'd2, 32'h11, 32'd0, 0, d, f);
    checkOutput("lw_misaligned_flag", 32'(f), 32'd1);
    runOp("sw_misaligned", 1'b1, 3'd2, 32'h12, 32'h55555555, 0, d, f);
    checkOutput("sw_misaligned_flag", 32'(f), 32'd1);
    runOp("lw_after_bad_sw", 1'b0, 3'd2, 32'h10, 32'd0, 0, d, f);
    checkOutput("lw_after_bad_sw_const", d, 32'h80ADBEEF);
    runOp("lw_out_of_range", 1'b0, 3'd2, 32'(4 * DEPTH), 32'd0, 0, d, f);
    checkOutput("lw_out_of_range_flag", 32'(f), 32'd1);
    runOp("load_f3_011", 1'b0, 3'd3, 32'h10, 32'd0, 0, d, f);
    checkOutput("load_f3_011_flag", 32'(f), 32'd1);

    // Backpressure: response held five cycles while a competing store is offered.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'd0;
    req_valid[0] = 1'b1;
    guard = 0;
    while (!bus_a.reqReady && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); req_valid[0] = 1'b0; lat++; end
    while (!bus_a.respValid && lat < 50);
    held = bus_a.memData;
    checkOutput("bp_first_data", held, 32'h80ADBEEF);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hA5A5A5A5;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_resp_valid", 32'(bus_a.respValid), 32'd1);
      checkOutput("bp_mem_data", bus_a.memData, held);
      checkOutput("bp_resp_fault", 32'(bus_a.respFault), 32'd0);
      checkOutput("bp_req_ready", 32'(bus_a.reqReady), 32'd0);
      @(negedge clk);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    checkOutput("bp_release_ready", 32'(bus_a.reqReady), 32'd1);
    checkOutput("bp_release_valid", 32'(bus_a.respValid), 32'd0);
    runOp("bp_store_ignored", 1'b0, 3'd2, 32'h30, 32'd0, 0, d, f);

    // Abort in WAIT, then abort exactly on the access edge; neither may write.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid[0] = 1'b1;
      guard = 0;
      while (!bus_a.reqReady && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      if (k == 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_resp_valid", 32'(bus_a.respValid), 32'd0);
      checkOutput("abort_req_ready", 32'(bus_a.reqReady), 32'd0);
      runOp("abort_lw_0x20", 1'b0, 3'd2, 32'h20, 32'd0, 0, d, f);
    end

    sel = 1'b1;
    applyStimulus(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 0, d, f, lat);
    checkOutput("zw_sw_latency", lat, 32'd1);
    checkOutput("zw_sw_data", d, 32'd0);
    checkOutput("zw_sw_fault", 32'(f), 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h40, 32'd0, 0, d, f, lat);
    checkOutput("zw_lw_latency", lat, 32'd1);
    checkOutput("zw_lw_data", d, 32'hCAFEF00D);
    checkOutput("zw_lw_fault", 32'(f), 32'd0);
    applyStimulus(1'b0, 3'd1, 32'h43, 32'd0, 0, d, f, lat);
    checkOutput("zw_lh_fault", 32'(f), 32'd1);
    checkOutput("zw_lh_data", d, 32'd0);
    sel = 1'b0;

    for (int n = 0; n < 200; n++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 15);
      if (r == 0)      a = 32'(4 * DEPTH) + $urandom_range(0, 4095);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 127);
      runOp("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            $urandom_range(0, 3), d, f);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
